tu_op_sequencer: RTL and testbench
==================================

TU_OP_SEQUENCER -- requirements
Module: tu_op_sequencer

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, number of TU entries (power of two, >=4).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles waited for op_resp.done.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  CP0 TLB instruction request.
REQ-006 SHALL have port cmd_op  in  tlb_op_t (2)  TLBR / TLBWI / TLBWR / TLBP.
REQ-007 SHALL have port cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready.
REQ-008 SHALL have port cmd_index  in  $clog2(TLB_ENTRIES)  CP0 Index for TLBR/TLBWI.
REQ-009 SHALL have port cmd_entry  in  tlb_entry_t  EntryHi/EntryLo0/EntryLo1/PageMask image for writes and probes.
REQ-010 SHALL have port wired  in  $clog2(TLB_ENTRIES)  CP0 Wired.
REQ-011 SHALL have port wired_we  in  1  Wired being written this cycle.
REQ-012 SHALL have port op_req  out  tu_op_req_t  request to TranslationUnit (valid, op, index, entry).
REQ-013 SHALL have port op_resp  in  tu_op_resp_t  TU response (done, hit, index, entry).
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port result_entry  out  tlb_entry_t  entry read by TLBR.
REQ-016 SHALL have port result_index  out  $clog2(TLB_ENTRIES)  index found by TLBP.
REQ-017 SHALL have port probe_miss  out  1  TLBP found no match (CP0 Index.P).
REQ-018 SHALL have port timed_out  out  1  op abandoned after TIMEOUT cycles.
REQ-019 SHALL have port random  out  $clog2(TLB_ENTRIES)  CP0 Random value.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, DONE.
REQ-021 IDLE SHALL drive cmd_ready=1, op_req.valid=0; on cmd_valid latch cmd_op, cmd_entry, and index (cmd_index, or random for TLBWR) and go to REQ.
REQ-022 REQ SHALL hold op_req.valid=1 with latched op/index/entry stable until leaving REQ; cmd_ready=0.
REQ-023 REQ SHALL go to DONE in the cycle op_resp.done=1, capturing op_resp.entry (TLBR), op_resp.index and !op_resp.hit (TLBP).
REQ-024 REQ SHALL count cycles from 0; if count reaches TIMEOUT without op_resp.done, go to DONE with timed_out=1 and result registers unchanged.
REQ-025 op_resp.done in the same cycle as the timeout SHALL count as success (timed_out=0).
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; minimum latency accept-to-done is 2 cycles (accept edge, done on cycle+2).
REQ-027 result_entry, result_index, probe_miss, timed_out SHALL be registered and held until the next DONE; probe_miss updated only by TLBP, result_entry only by TLBR.
REQ-028 op_resp SHALL be ignored outside REQ.
REQ-029 random SHALL decrement by 1 every cycle; when random<=wired it SHALL reload TLB_ENTRIES-1 on the next cycle.
REQ-030 wired_we=1 SHALL force random to TLB_ENTRIES-1 next cycle, overriding decrement.
REQ-031 wired>=TLB_ENTRIES-1 SHALL hold random at TLB_ENTRIES-1.
REQ-032 TLBWR SHALL use the random value sampled in the accept cycle.

Reset
REQ-033 reset SHALL asynchronously force IDLE, counter 0, random=TLB_ENTRIES-1, done=0, timed_out=0, probe_miss=0, result_entry=0, result_index=0, op_req=0.
REQ-034 reset during REQ SHALL drop op_req.valid immediately with no done pulse.

Structure
REQ-035 tlb_op_t, tlb_entry_t, tu_op_req_t, tu_op_resp_t SHALL live in the shared tu package header.
REQ-036 Random generator SHALL be a sub-module tlb_random_gen (clk, reset, wired, wired_we, random).

Verification
REQ-037 TLBWI index 5 with TU done 3 cycles after valid -> op_req.index=5 held stable 3 cycles, done pulse one cycle later, timed_out=0.
REQ-038 TLBP, TU returns done same cycle, hit=0 -> done at accept+2, probe_miss=1; then TLBP hit index 9 -> result_index=9, probe_miss=0.
REQ-039 TLBR with tied-off op_resp=0 -> op_req.valid held 16 cycles (TIMEOUT=15), done with timed_out=1, result_entry unchanged.
REQ-040 wired=3, TLB_ENTRIES=16 -> random sequence 15,14,...,3,15; wired_we mid-sequence -> 15 next cycle.
REQ-041 TLBWR accepted when random=7 -> op_req.index=7 despite random advancing during REQ.
REQ-042 reset asserted in REQ -> op_req.valid=0 and cmd_ready=1 immediately, no done pulse, random=15.

Source files
------------

// File: rtl/tu_op_sequencer_pkg.sv
// Shared TranslationUnit types for the CP0 TLB instruction path.
//   tlb_op_t      : TLB instruction opcode (TLBR / TLBWI / TLBWR / TLBP)
//   tlb_entry_t   : EntryHi / EntryLo0 / EntryLo1 / PageMask image
//   tu_op_req_t   : request to the TranslationUnit
//   tu_op_resp_t  : response from the TranslationUnit
// TU_IDX_W is the index width carried on the TU bus. It limits the design to
// at most 2**TU_IDX_W entries, and narrower tables zero-extend onto it.
package tu_op_sequencer_pkg;

  localparam int TU_IDX_W = 6;

  typedef enum logic [1:0] {
    TLBR  = 2'd0,
    TLBWI = 2'd1,
    TLBWR = 2'd2,
    TLBP  = 2'd3
  } tlb_op_t;

  typedef struct packed {
    logic [31:0] entry_hi;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
    logic [31:0] page_mask;
  } tlb_entry_t;

  typedef struct packed {
    logic                valid;
    tlb_op_t             op;
    logic [TU_IDX_W-1:0] index;
    tlb_entry_t          entry;
  } tu_op_req_t;

  typedef struct packed {
    logic                done;
    logic                hit;
    logic [TU_IDX_W-1:0] index;
    tlb_entry_t          entry;
  } tu_op_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tu_op_sequencer_random_gen.sv
// tlb_random_gen: CP0 Random register.
//   clk, reset : clock and asynchronous active-high reset
//   wired      : CP0 Wired value
//   wired_we   : Wired is being written this cycle
//   random     : current Random value
// Random counts down by one each cycle. Once it reaches Wired (or below), or
// Wired is rewritten, or Wired covers the whole table, it goes back to the top
// entry.
module tlb_random_gen #(
  parameter  int TLB_ENTRIES = 16,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] random_d;

  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (wired_we || (wired >= RAND_MAX) || (random_q <= wired)) begin
      random_d = RAND_MAX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/tu_op_sequencer.sv
// tu_op_sequencer: issues one CP0 TLB instruction at a time to the
// TranslationUnit and collects the result.
//   cmd_valid/cmd_ready/cmd_op/cmd_index/cmd_entry : instruction request
//   wired/wired_we       : CP0 Wired, which feeds the Random generator
//   op_req/op_resp       : TranslationUnit request / response
//   done                 : one-cycle completion pulse
//   result_entry         : entry returned by the last TLBR
//   result_index         : index returned by the last TLBP
//   probe_miss           : last TLBP found no match
//   timed_out            : last op was abandoned with no TU response
//   random               : CP0 Random
//
// state   | meaning
// IDLE    | ready for a command, no TU request outstanding
// REQ     | request held on op_req until TU done or the timeout expires
// DONE    | done pulse, results updated on entry
import tu_op_sequencer_pkg::*;

module tu_op_sequencer #(
  parameter  int TLB_ENTRIES = 16,
  parameter  int TIMEOUT     = 15,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  tlb_op_t          cmd_op,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_index,
  input  tlb_entry_t       cmd_entry,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output tu_op_req_t       op_req,
  input  tu_op_resp_t      op_resp,
  output logic             done,
  output tlb_entry_t       result_entry,
  output logic [IDX_W-1:0] result_index,
  output logic             probe_miss,
  output logic             timed_out,
  output logic [IDX_W-1:0] random
);

  localparam int               CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  tu_op_req_t       op_req_q;
  logic             done_q;
  logic             timed_out_q;
  logic             probe_miss_q;
  tlb_entry_t       result_entry_q;
  logic [IDX_W-1:0] result_index_q;
  logic [IDX_W-1:0] random_w;

  // Upper TU index bits are always zero for tables narrower than the bus.
  logic unused_resp_idx;
  assign unused_resp_idx = ^op_resp.index;

  tlb_random_gen #(
    .TLB_ENTRIES(TLB_ENTRIES)
  ) u_random_gen (
    .clk     (clk),
    .reset   (reset),
    .wired   (wired),
    .wired_we(wired_we),
    .random  (random_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_req_q       <= '0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      probe_miss_q   <= 1'b0;
      result_entry_q <= '0;
      result_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            // TLBWR takes Random as it stands in the accept cycle.
            op_req_q.valid <= 1'b1;
            op_req_q.op    <= cmd_op;
            op_req_q.index <= TU_IDX_W'((cmd_op == TLBWR) ? random_w : cmd_index);
            op_req_q.entry <= cmd_entry;
            cnt_q          <= '0;
            state_q        <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A response arriving in the final timeout cycle still wins.
          if (op_resp.done) begin
            op_req_q.valid <= 1'b0;
            done_q         <= 1'b1;
            timed_out_q    <= 1'b0;
            if (op_req_q.op == TLBR) begin
              result_entry_q <= op_resp.entry;
            end
            if (op_req_q.op == TLBP) begin
              result_index_q <= IDX_W'(op_resp.index);
              probe_miss_q   <= ~op_resp.hit;
            end
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            op_req_q.valid <= 1'b0;
            done_q         <= 1'b1;
            timed_out_q    <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign op_req       = op_req_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign probe_miss   = probe_miss_q;
  assign result_entry = result_entry_q;
  assign result_index = result_index_q;
  assign random       = random_w;

endmodule

// File: tb/tb_tu_op_sequencer.sv
import tu_op_sequencer_pkg::*;

module tb_tu_op_sequencer;

  localparam int IDX_W = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  tlb_op_t          cmd_op;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_index;
  tlb_entry_t       cmd_entry;
  logic [IDX_W-1:0] wired;
  logic             wired_we;
  tu_op_req_t       op_req;
  tu_op_resp_t      op_resp;
  logic             done;
  tlb_entry_t       result_entry;
  logic [IDX_W-1:0] result_index;
  logic             probe_miss;
  logic             timed_out;
  logic [IDX_W-1:0] random;

  int checks = 0;
  int errors = 0;

  tu_op_sequencer #(.TLB_ENTRIES(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .cmd_index   (cmd_index),
    .cmd_entry   (cmd_entry),
    .wired       (wired),
    .wired_we    (wired_we),
    .op_req      (op_req),
    .op_resp     (op_resp),
    .done        (done),
    .result_entry(result_entry),
    .result_index(result_index),
    .probe_miss  (probe_miss),
    .timed_out   (timed_out),
    .random      (random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    tlb_op_t             op;
    logic [IDX_W-1:0]    index;
    tlb_entry_t          entry;
    int                  resp_cycle;  // REQ cycle (1-based) carrying TU done, 0 = never
    logic                hit;
    logic [TU_IDX_W-1:0] resp_index;
    tlb_entry_t          resp_entry;
    int                  exp_cycles;
    logic                exp_to;
    logic                exp_pm;
    logic [IDX_W-1:0]    exp_ri;
    tlb_entry_t          exp_re;
  } vec_t;

  localparam tlb_entry_t E0 = '0;
  localparam tlb_entry_t EA = '{32'hA000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
  localparam tlb_entry_t E1 = '{32'h1234_5000, 32'h0000_1F07, 32'h0000_2F07, 32'h0000_6000};
  localparam tlb_entry_t E2 = '{32'hDEAD_B000, 32'h0BAD_0003, 32'h0BAD_0005, 32'h0001_E000};
  localparam tlb_entry_t E3 = '{32'h7777_2000, 32'h0004_4417, 32'h0004_5517, 32'h0000_0000};

  vec_t vecs [9];

  task automatic run_vec(input vec_t v, input int k);
    int   n;
    logic stable;
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", k), 128'(cmd_ready), 128'(1'b1));
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_index = v.index;
    cmd_entry = v.entry;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_entry = E2;
    cmd_index = ~v.index;
    n = 0;
    stable = 1'b1;
    while (op_req.valid && n < 40) begin
      n++;
      if (op_req.op !== v.op || op_req.index !== TU_IDX_W'(v.index) ||
          op_req.entry !== v.entry || cmd_ready !== 1'b0 || done !== 1'b0)
        stable = 1'b0;
      if (n == v.resp_cycle)
        op_resp = '{done: 1'b1, hit: v.hit, index: v.resp_index, entry: v.resp_entry};
      else
        op_resp = '0;
      @(negedge clk);
    end
    op_resp = '0;
    chk($sformatf("v%0d_valid_cycles", k), 128'(n), 128'(v.exp_cycles));
    chk($sformatf("v%0d_req_stable", k), 128'(stable), 128'(1'b1));
    chk($sformatf("v%0d_done_pulse", k), 128'(done), 128'(1'b1));
    chk($sformatf("v%0d_timed_out", k), 128'(timed_out), 128'(v.exp_to));
    chk($sformatf("v%0d_probe_miss", k), 128'(probe_miss), 128'(v.exp_pm));
    chk($sformatf("v%0d_result_index", k), 128'(result_index), 128'(v.exp_ri));
    chk($sformatf("v%0d_result_entry", k), 128'(result_entry), 128'(v.exp_re));
    // a stray response outside REQ must leave everything untouched
    op_resp = '{done: 1'b1, hit: 1'b0, index: 6'd13, entry: '1};
    @(negedge clk);
    op_resp = '0;
    chk($sformatf("v%0d_done_once", k), 128'(done), 128'(1'b0));
    chk($sformatf("v%0d_ready_after", k), 128'(cmd_ready), 128'(1'b1));
    chk($sformatf("v%0d_ri_after_stray", k), 128'(result_index), 128'(v.exp_ri));
    chk($sformatf("v%0d_re_after_stray", k), 128'(result_entry), 128'(v.exp_re));
  endtask

  initial begin
    logic [IDX_W-1:0] exp_rand;
    bit               found;

    vecs[0] = '{TLBWI, 4'd5,  EA, 3,  1'b1, 6'd0,  E0, 3,  1'b0, 1'b0, 4'd0,  E0};
    vecs[1] = '{TLBP,  4'd0,  EA, 1,  1'b0, 6'd2,  E0, 1,  1'b0, 1'b1, 4'd2,  E0};
    vecs[2] = '{TLBP,  4'd0,  E1, 2,  1'b1, 6'd9,  E0, 2,  1'b0, 1'b0, 4'd9,  E0};
    vecs[3] = '{TLBR,  4'd3,  E0, 4,  1'b1, 6'd3,  E1, 4,  1'b0, 1'b0, 4'd9,  E1};
    vecs[4] = '{TLBR,  4'd1,  E0, 0,  1'b1, 6'd1,  E2, 16, 1'b1, 1'b0, 4'd9,  E1};
    vecs[5] = '{TLBP,  4'd0,  E3, 16, 1'b0, 6'd11, E0, 16, 1'b0, 1'b1, 4'd11, E1};
    vecs[6] = '{TLBWI, 4'd15, E3, 1,  1'b1, 6'd4,  E2, 1,  1'b0, 1'b1, 4'd11, E1};
    vecs[7] = '{TLBP,  4'd0,  EA, 0,  1'b1, 6'd7,  E0, 16, 1'b1, 1'b1, 4'd11, E1};
    vecs[8] = '{TLBR,  4'd0,  E0, 1,  1'b1, 6'd0,  E3, 1,  1'b0, 1'b1, 4'd11, E3};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = TLBR;
    cmd_index = '0;
    cmd_entry = '0;
    wired     = '0;
    wired_we  = 1'b0;
    op_resp   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    chk("rst_op_req", 128'(op_req), 128'(0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_timed_out", 128'(timed_out), 128'(1'b0));
    chk("rst_probe_miss", 128'(probe_miss), 128'(1'b0));
    chk("rst_result_entry", 128'(result_entry), 128'(0));
    chk("rst_result_index", 128'(result_index), 128'(0));
    chk("rst_random", 128'(random), 128'(15));

    // Random with wired=3: 15 down to 3, then reload to 15
    wired    = 4'd3;
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i <= 12) exp_rand = 4'(15 - i);
      else if (i == 13) exp_rand = 4'd15;
      else exp_rand = 4'd14;
      chk($sformatf("rand_seq_%0d", i), 128'(random), 128'(exp_rand));
      @(negedge clk);
    end
    chk("rand_before_we", 128'(random), 128'(13));
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    chk("rand_wired_we", 128'(random), 128'(15));
    wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rand_hold_%0d", i), 128'(random), 128'(15));
    end
    wired = 4'd0;
    @(negedge clk);
    chk("rand_free_0", 128'(random), 128'(14));
    @(negedge clk);
    chk("rand_free_1", 128'(random), 128'(13));

    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

    // TLBWR accepted when random=7 keeps index 7 while random moves on
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (random == 4'd7) found = 1'b1;
    end
    chk("tlbwr_found_rand7", 128'(found), 128'(1'b1));
    cmd_valid = 1'b1;
    cmd_op    = TLBWR;
    cmd_index = 4'd2;
    cmd_entry = E1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("tlbwr_valid_%0d", c), 128'(op_req.valid), 128'(1'b1));
      chk($sformatf("tlbwr_index_%0d", c), 128'(op_req.index), 128'(7));
      if (c == 3) op_resp = '{done: 1'b1, hit: 1'b0, index: 6'd0, entry: E0};
      @(negedge clk);
    end
    op_resp = '0;
    chk("tlbwr_random_moved", 128'(random), 128'(3));
    chk("tlbwr_done", 128'(done), 128'(1'b1));
    chk("tlbwr_valid_drop", 128'(op_req.valid), 128'(1'b0));

    // reset in the middle of REQ
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = TLBR;
    cmd_index = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstreq_in_req", 128'(op_req.valid), 128'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("rstreq_valid", 128'(op_req.valid), 128'(1'b0));
    chk("rstreq_ready", 128'(cmd_ready), 128'(1'b1));
    chk("rstreq_done", 128'(done), 128'(1'b0));
    chk("rstreq_random", 128'(random), 128'(15));
    chk("rstreq_probe_miss", 128'(probe_miss), 128'(1'b0));
    chk("rstreq_result_index", 128'(result_index), 128'(0));
    chk("rstreq_result_entry", 128'(result_entry), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstreq_no_done_%0d", i), 128'(done), 128'(1'b0));
      chk($sformatf("rstreq_idle_%0d", i), 128'(cmd_ready), 128'(1'b1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
